alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl_pkg.sv | 18 +
 rtl/alu_issue_ctrl_alu.sv | 66 ++++++
 rtl/alu_issue_ctrl.sv | 159 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared types for the ALU issue controller: opcode encoding and FSM states.
// Used by alu_issue_ctrl and its alu sub-module.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_MUL = 2'b01,
    OP_DIV = 2'b10,
    OP_SUB = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_issue_ctrl_alu.sv
// Combinational ALU: add/sub/mul/div on unsigned WIDTH+1-bit operands with
// zero/negative/carry/overflow flags and a divide-by-zero indication.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  op_e              op,
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH:0]   b,
  input  logic             ci,
  output logic [WIDTH:0]   result,
  output logic             cero,
  output logic             negativo,
  output logic             acarreo,
  output logic             desbordamiento,
  output logic             div0
);

  localparam int W1 = WIDTH + 1;

  logic [W1:0]     sum;
  logic [W1-1:0]   diff;
  logic [2*W1-1:0] prod;

  assign sum  = {1'b0, a} + {1'b0, b} + {{W1{1'b0}}, ci};
  assign diff = a - b;
  assign prod = {{W1{1'b0}}, a} * {{W1{1'b0}}, b};

  // Overflow uses the sign bits of the operands and the truncated result.
  always_comb begin
    result         = '0;
    acarreo        = 1'b0;
    desbordamiento = 1'b0;
    div0           = 1'b0;
    case (op)
      OP_ADD: begin
        result         = sum[W1-1:0];
        acarreo        = sum[W1];
        desbordamiento = (a[W1-1] == b[W1-1]) && (sum[W1-1] != a[W1-1]);
      end
      OP_SUB: begin
        result         = diff;
        acarreo        = (a >= b);
        desbordamiento = (a[W1-1] != b[W1-1]) && (diff[W1-1] != a[W1-1]);
      end
      OP_MUL: begin
        result  = prod[W1-1:0];
        acarreo = |prod[2*W1-1:W1];
      end
      OP_DIV: begin
        if (b == '0) begin
          result = '1;
          div0   = 1'b1;
        end else begin
          result = a / b;
        end
      end
      default: ;
    endcase
  end

  assign cero     = (result == '0);
  assign negativo = result[W1-1];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Three-state issue controller (IDLE/EXEC/DONE) around a combinational alu.
// Optional macro ALU_ISSUE_STATS_EN adds a 16-bit response counter op_count.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH:0]   req_a,
  input  logic [WIDTH:0]   req_b,
  input  logic             req_ci,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH:0]   rsp_out,
  output logic             rsp_cero,
  output logic             rsp_negativo,
  output logic             rsp_acarreo,
  output logic             rsp_desbordamiento,
  output logic             rsp_div0,
  output logic             busy
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [15:0]      op_count
`endif
);

  state_e         state_q, state_d;
  op_e            op_q, op_d;
  logic [WIDTH:0] a_q, a_d, b_q, b_d;
  logic           ci_q, ci_d;
  logic [WIDTH:0] out_q, out_d;
  logic           cero_q, cero_d, neg_q, neg_d, carry_q, carry_d;
  logic           ovf_q, ovf_d, div0_q, div0_d;
  logic           req_ready_q, req_ready_d, busy_q, busy_d;
  logic           rsp_valid_q, rsp_valid_d;

  logic [WIDTH:0] alu_result;
  logic           alu_cero, alu_neg, alu_carry, alu_ovf, alu_div0;

  alu #(.WIDTH(WIDTH)) u_alu (
    .op             (op_q),
    .a              (a_q),
    .b              (b_q),
    .ci             (ci_q),
    .result         (alu_result),
    .cero           (alu_cero),
    .negativo       (alu_neg),
    .acarreo        (alu_carry),
    .desbordamiento (alu_ovf),
    .div0           (alu_div0)
  );

  // Status outputs are registered from the next state so they line up with it.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    ci_d    = ci_q;
    out_d   = out_q;
    cero_d  = cero_q;
    neg_d   = neg_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    div0_d  = div0_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d    = op_e'(req_op);
          a_d     = req_a;
          b_d     = req_b;
          ci_d    = req_ci;
          state_d = EXEC;
        end
      end
      EXEC: begin
        out_d   = alu_result;
        cero_d  = alu_cero;
        neg_d   = alu_neg;
        carry_d = alu_carry;
        ovf_d   = alu_ovf;
        div0_d  = alu_div0;
        state_d = DONE;
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    rsp_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= OP_ADD;
      a_q         <= '0;
      b_q         <= '0;
      ci_q        <= 1'b0;
      out_q       <= '0;
      cero_q      <= 1'b0;
      neg_q       <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      div0_q      <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ci_q        <= ci_d;
      out_q       <= out_d;
      cero_q      <= cero_d;
      neg_q       <= neg_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      div0_q      <= div0_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] op_count_q, op_count_d;

  always_comb begin
    op_count_d = op_count_q;
    if (state_q == DONE && rsp_ready) op_count_d = op_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) op_count_q <= '0;
    else        op_count_q <= op_count_d;
  end

  assign op_count = op_count_q;
`endif

  assign req_ready          = req_ready_q;
  assign busy               = busy_q;
  assign rsp_valid          = rsp_valid_q;
  assign rsp_out            = out_q;
  assign rsp_cero           = cero_q;
  assign rsp_negativo       = neg_q;
  assign rsp_acarreo        = carry_q;
  assign rsp_desbordamiento = ovf_q;
  assign rsp_div0           = div0_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl (WIDTH=3): vector table plus
// scoreboard queue, with hold/back-pressure and reset-during-EXEC sequences.
module tb_alu_issue_ctrl;

  localparam int WIDTH = 3;

  typedef struct {
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       ci;
    logic [3:0] exp_out;
    logic [4:0] exp_flags;
    int         hold;
  } entry_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [3:0] req_a, req_b;
  logic       req_ci;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_out;
  logic       rsp_cero, rsp_negativo, rsp_acarreo, rsp_desbordamiento, rsp_div0;
  logic       busy;
`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] op_count;
  logic [15:0] exp_count;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;
  entry_t vec[14];
  entry_t sb_q[$];

  alu_issue_ctrl #(.WIDTH(WIDTH)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_op             (req_op),
    .req_a              (req_a),
    .req_b              (req_b),
    .req_ci             (req_ci),
    .rsp_valid          (rsp_valid),
    .rsp_ready          (rsp_ready),
    .rsp_out            (rsp_out),
    .rsp_cero           (rsp_cero),
    .rsp_negativo       (rsp_negativo),
    .rsp_acarreo        (rsp_acarreo),
    .rsp_desbordamiento (rsp_desbordamiento),
    .rsp_div0           (rsp_div0),
    .busy               (busy)
`ifdef ALU_ISSUE_STATS_EN
    ,
    .op_count           (op_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [4:0] flags_now();
    return {rsp_cero, rsp_negativo, rsp_acarreo, rsp_desbordamiento, rsp_div0};
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic applyStimulus(input entry_t e);
    int waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("accept_wait", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op    = e.op;
    req_a     = e.a;
    req_b     = e.b;
    req_ci    = e.ci;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("exec_status", {29'd0, busy, req_ready, rsp_valid}, 32'b100);
  endtask

  task automatic checkOutput(input int hold);
    entry_t e;
    int lat = 0;
    while (!rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 1);
    if (sb_q.size() == 0) begin
      total_cnt++;
      $display("[TB] FAIL scoreboard: got empty queue expected an entry");
      return;
    end
    e = sb_q.pop_front();
    check("rsp_out", {28'd0, rsp_out}, {28'd0, e.exp_out});
    check("rsp_flags", {27'd0, flags_now()}, {27'd0, e.exp_flags});
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      req_op    = 2'(i);
      req_a     = 4'(i + 3);
      req_b     = 4'(i + 1);
      @(negedge clk);
      check("hold_stable", {21'd0, rsp_valid, req_ready, rsp_out, flags_now()},
            {21'd0, 1'b1, 1'b0, e.exp_out, e.exp_flags});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("after_handshake", {29'd0, rsp_valid, req_ready, busy}, 32'b010);
    req_valid = 1'b0;
`ifdef ALU_ISSUE_STATS_EN
    exp_count++;
    check("op_count", {16'd0, op_count}, {16'd0, exp_count});
`endif
  endtask

  initial begin
    vec[0]  = '{2'b00, 4'd9,  4'd8, 1'b0, 4'h1, 5'b00110, 0};
    vec[1]  = '{2'b11, 4'd3,  4'd5, 1'b0, 4'hE, 5'b01000, 5};
    vec[2]  = '{2'b01, 4'd5,  4'd4, 1'b0, 4'h4, 5'b00100, 0};
    vec[3]  = '{2'b10, 4'd7,  4'd2, 1'b0, 4'h3, 5'b00000, 1};
    vec[4]  = '{2'b10, 4'd7,  4'd0, 1'b0, 4'hF, 5'b01001, 0};
    vec[5]  = '{2'b00, 4'd3,  4'd4, 1'b1, 4'h8, 5'b01010, 0};
    vec[6]  = '{2'b00, 4'd15, 4'd1, 1'b0, 4'h0, 5'b10100, 2};
    vec[7]  = '{2'b11, 4'd8,  4'd1, 1'b1, 4'h7, 5'b00110, 0};
    vec[8]  = '{2'b11, 4'd5,  4'd5, 1'b0, 4'h0, 5'b10100, 0};
    vec[9]  = '{2'b01, 4'd15, 4'd15, 1'b0, 4'h1, 5'b00100, 0};
    vec[10] = '{2'b01, 4'd3,  4'd5, 1'b0, 4'hF, 5'b01000, 0};
    vec[11] = '{2'b10, 4'd0,  4'd0, 1'b0, 4'hF, 5'b01001, 0};
    vec[12] = '{2'b10, 4'd2,  4'd9, 1'b0, 4'h0, 5'b10000, 0};
    vec[13] = '{2'b10, 4'd15, 4'd1, 1'b0, 4'hF, 5'b01000, 0};

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_a     = 4'd0;
    req_b     = 4'd0;
    req_ci    = 1'b0;
    rsp_ready = 1'b0;
`ifdef ALU_ISSUE_STATS_EN
    exp_count = 16'd0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_req_ready", {31'd0, req_ready}, 32'd1);
    check("reset_rsp_out", {28'd0, rsp_out}, 32'd0);
    check("reset_flags", {27'd0, flags_now()}, 32'd0);
`ifdef ALU_ISSUE_STATS_EN
    check("reset_op_count", {16'd0, op_count}, 32'd0);
`endif

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vec[i]);
      checkOutput(vec[i].hold);
    end

    // Reset while the op sits in EXEC: it must vanish without a response.
    applyStimulus(vec[0]);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    void'(sb_q.pop_back());
`ifdef ALU_ISSUE_STATS_EN
    exp_count = 16'd0;
    check("exec_reset_op_count", {16'd0, op_count}, {16'd0, exp_count});
`endif
    check("exec_reset_state", {21'd0, rsp_valid, busy, req_ready, rsp_out, flags_now()},
          {21'd0, 1'b0, 1'b0, 1'b1, 4'h0, 5'h0});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_rsp_after_reset", {30'd0, rsp_valid, busy}, 32'd0);
    end

    applyStimulus(vec[2]);
    checkOutput(0);
    applyStimulus(vec[1]);
    checkOutput(1);

    $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
